// File: rtl/covox_sd_dac_if.sv
// Bus-side signals of the covox DAC: strobe, data bus and beeper/tape levels in,
// captured sample, status and 1-bit audio out.
interface covox_sd_dac_if;
   logic       covox;
   logic [7:0] d;
   logic       beeper;
   logic       tapeout;
   logic [7:0] sample;
   logic       sample_upd;
   logic       idle;
   logic       pdm_out;

   modport master (
      output covox, d, beeper, tapeout,
      input  sample, sample_upd, idle, pdm_out
   );

   modport slave (
      input  covox, d, beeper, tapeout,
      output sample, sample_upd, idle, pdm_out
   );
endinterface

// File: rtl/covox_sd_dac.sv
// Covox sample capture, beeper/tape mixer and first-order sigma-delta 1-bit DAC.
// The sample returns to MIDSCALE after 2^IDLE_W-1 clocks without a covox write.
module covox_sd_dac #(
   parameter int unsigned BEEP_AMP = 96,
   parameter int unsigned TAPE_AMP = 32,
   parameter int unsigned IDLE_W   = 20,
   parameter logic [7:0]  MIDSCALE = 8'h80
) (
   input logic           cpu_clock,
   input logic           reset,
   covox_sd_dac_if.slave bus
);
   localparam logic [9:0] BeepAmp = 10'(BEEP_AMP);
   localparam logic [9:0] TapeAmp = 10'(TAPE_AMP);

   logic              s1_q, s2_q, s3_q;
   logic [7:0]        d1_q, d2_q;
   logic [7:0]        hold_q, hold_d;
   logic [7:0]        sample_q, sample_d;
   logic              upd_q;
   logic              idle_q, idle_d;
   logic [IDLE_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [7:0]        acc_q;
   logic              pdm_q;
   logic              commit, cnt_sat, timeout;
   logic [9:0]        mix10;
   logic [7:0]        mix8;
   logic [8:0]        sum9;

   always_comb begin
      commit  = s3_q & ~s2_q;
      cnt_inc = cnt_q + IDLE_W'(1);
      cnt_sat = &cnt_q;
      // Fires only on the step into all-ones, so a saturated counter reloads once.
      timeout = ~cnt_sat & (&cnt_inc);

      hold_d = s2_q ? d2_q : hold_q;

      sample_d = sample_q;
      idle_d   = idle_q;
      cnt_d    = cnt_sat ? cnt_q : cnt_inc;
      if (commit) begin
         sample_d = hold_q;
         idle_d   = 1'b0;
         cnt_d    = '0;
      end else if (timeout) begin
         sample_d = MIDSCALE;
         idle_d   = 1'b1;
      end

      mix10 = {3'b000, sample_q[7:1]}
            + (bus.beeper  ? BeepAmp : 10'd0)
            + (bus.tapeout ? TapeAmp : 10'd0);
      mix8  = (mix10 > 10'd255) ? 8'hFF : mix10[7:0];
      sum9  = {1'b0, acc_q} + {1'b0, mix8};
   end

   always_ff @(posedge cpu_clock or negedge reset) begin
      if (!reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         d1_q     <= 8'h00;
         d2_q     <= 8'h00;
         hold_q   <= MIDSCALE;
         sample_q <= MIDSCALE;
         upd_q    <= 1'b0;
         idle_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= 8'h00;
         pdm_q    <= 1'b0;
      end else begin
         s1_q     <= bus.covox;
         s2_q     <= s1_q;
         s3_q     <= s2_q;
         d1_q     <= bus.d;
         d2_q     <= d1_q;
         hold_q   <= hold_d;
         sample_q <= sample_d;
         upd_q    <= commit;
         idle_q   <= idle_d;
         cnt_q    <= cnt_d;
         acc_q    <= sum9[7:0];
         pdm_q    <= sum9[8];
      end
   end

   assign bus.sample     = sample_q;
   assign bus.sample_upd = upd_q;
   assign bus.idle       = idle_q;
   assign bus.pdm_out    = pdm_q;
endmodule

// File: tb/tb_covox_sd_dac.sv
// Bench for covox_sd_dac: two instances (default, and IDLE_W=4 / BEEP_AMP=200) on shared
// stimulus, checked each cycle against a behavioural model plus literal expectations.
module tb_covox_sd_dac;
   logic       clk;
   logic       rst_n;
   logic       covox;
   logic [7:0] dbus;
   logic       beeper;
   logic       tapeout;

   int total = 0;
   int bad   = 0;

   covox_sd_dac_if ifa ();
   covox_sd_dac_if ifb ();

   assign ifa.covox   = covox;
   assign ifa.d       = dbus;
   assign ifa.beeper  = beeper;
   assign ifa.tapeout = tapeout;
   assign ifb.covox   = covox;
   assign ifb.d       = dbus;
   assign ifb.beeper  = beeper;
   assign ifb.tapeout = tapeout;

   covox_sd_dac #(.IDLE_W(20)) dut_a (
      .cpu_clock (clk),
      .reset     (rst_n),
      .bus       (ifa)
   );

   covox_sd_dac #(.BEEP_AMP(200), .IDLE_W(4)) dut_b (
      .cpu_clock (clk),
      .reset     (rst_n),
      .bus       (ifb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int mix_f(input int s, input bit b, input bit t, input int ba);
      int m;
      m = s / 2 + (b ? ba : 0) + (t ? 32 : 0);
      return (m > 255) ? 255 : m;
   endfunction

   function automatic int lim_f(input int i);
      return (i == 0) ? ((1 << 20) - 1) : 15;
   endfunction

   function automatic int ba_f(input int i);
      return (i == 0) ? 96 : 200;
   endfunction

   int     m_sample [2];
   bit     m_upd    [2];
   bit     m_idle   [2];
   bit     m_pdm    [2];
   int     m_since  [2];
   longint m_tot    [2];
   bit     hc       [1:3];
   int     hd       [1:3];

   // A write lands three edges after the bus value was taken at the last strobe-high edge;
   // the PDM bit is the carry of the running total of all mix values since reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_sample[i] <= 8'h80;
            m_upd[i]    <= 1'b0;
            m_idle[i]   <= 1'b0;
            m_pdm[i]    <= 1'b0;
            m_since[i]  <= 0;
            m_tot[i]    <= 0;
         end
         for (int j = 1; j <= 3; j++) begin
            hc[j] <= 1'b0;
            hd[j] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_tot[i] <= m_tot[i] + mix_f(m_sample[i], beeper, tapeout, ba_f(i));
            m_pdm[i] <= ((m_tot[i] + mix_f(m_sample[i], beeper, tapeout, ba_f(i))) / 256)
                        != (m_tot[i] / 256);
            m_upd[i] <= hc[3] && !hc[2];
            if (hc[3] && !hc[2]) begin
               m_sample[i] <= hd[3];
               m_idle[i]   <= 1'b0;
               m_since[i]  <= 0;
            end else begin
               if (m_since[i] != lim_f(i)) m_since[i] <= m_since[i] + 1;
               if (m_since[i] == lim_f(i) - 1) begin
                  m_sample[i] <= 8'h80;
                  m_idle[i]   <= 1'b1;
               end
            end
         end
         hc[1] <= covox;
         hc[2] <= hc[1];
         hc[3] <= hc[2];
         hd[1] <= int'(dbus);
         hd[2] <= hd[1];
         hd[3] <= hd[2];
      end
   end

   always @(negedge clk) begin
      chk("a.sample", int'(ifa.sample), m_sample[0]);
      chk("a.upd", int'(ifa.sample_upd), int'(m_upd[0]));
      chk("a.idle", int'(ifa.idle), int'(m_idle[0]));
      chk("a.pdm", int'(ifa.pdm_out), int'(m_pdm[0]));
      chk("b.sample", int'(ifb.sample), m_sample[1]);
      chk("b.upd", int'(ifb.sample_upd), int'(m_upd[1]));
      chk("b.idle", int'(ifb.idle), int'(m_idle[1]));
      chk("b.pdm", int'(ifb.pdm_out), int'(m_pdm[1]));
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [7:0] v, input int hi);
      covox = 1'b1;
      dbus  = v;
      cyc(hi);
      covox = 1'b0;
   endtask

   task automatic wait_upd(input string name, input bit use_b, input int exp_lat);
      int lat;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         if ((use_b ? ifb.sample_upd : ifa.sample_upd) == 1'b1) begin
            lat = i;
            break;
         end
      end
      chk(name, lat, exp_lat);
   endtask

   task automatic count_ones(input int n, output int ca, output int cb, output int nu);
      ca = 0;
      cb = 0;
      nu = 0;
      repeat (n) begin
         cyc(1);
         ca += int'(ifa.pdm_out);
         cb += int'(ifb.pdm_out);
         nu += int'(ifa.sample_upd);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ca, cb, nu;
      clk     = 1'b0;
      covox   = 1'b0;
      dbus    = 8'h00;
      beeper  = 1'b0;
      tapeout = 1'b0;
      rst_n   = 1'b0;
      cyc(3);
      #2 rst_n = 1'b1;

      // Idle after reset: mix 0x40
      count_ones(256, ca, cb, nu);
      chk("rst_density", ca, 64);
      chk("rst_no_upd", nu, 0);
      chk("rst_sample", int'(ifa.sample), 8'h80);
      chk("rst_idle", int'(ifa.idle), 0);

      // Write 0xFE, mix 127
      strobe(8'hFE, 3);
      wait_upd("lat_fe", 1'b0, 3);
      chk("sample_fe", int'(ifa.sample), 8'hFE);
      count_ones(256, ca, cb, nu);
      chk("density_fe", ca, 127);
      chk("single_upd_fe", nu, 0);

      // Full mix and saturation
      beeper  = 1'b1;
      tapeout = 1'b1;
      strobe(8'hFF, 3);
      wait_upd("lat_ff", 1'b0, 3);
      count_ones(256, ca, cb, nu);
      chk("density_ff_a", ca, 255);
      chk("density_sat_b", cb, 255);

      beeper  = 1'b0;
      tapeout = 1'b0;
      strobe(8'h00, 3);
      wait_upd("lat_00", 1'b0, 3);
      count_ones(256, ca, cb, nu);
      chk("density_zero", ca, 0);

      // Idle timeout on the short-counter instance
      strobe(8'h10, 3);
      wait_upd("lat_10", 1'b1, 3);
      cyc(14);
      chk("b_pre_to_sample", int'(ifb.sample), 8'h10);
      chk("b_pre_to_idle", int'(ifb.idle), 0);
      cyc(1);
      chk("b_to_sample", int'(ifb.sample), 8'h80);
      chk("b_to_idle", int'(ifb.idle), 1);
      cyc(20);
      chk("b_sat_sample", int'(ifb.sample), 8'h80);
      chk("b_sat_idle", int'(ifb.idle), 1);
      chk("a_not_idle", int'(ifa.idle), 0);
      strobe(8'h22, 3);
      wait_upd("lat_22", 1'b1, 3);
      chk("b_wr_sample", int'(ifb.sample), 8'h22);
      chk("b_wr_idle", int'(ifb.idle), 0);

      // Commit lands on the exact timeout edge (15 edges after the 0x22 commit)
      cyc(9);
      covox = 1'b1;
      dbus  = 8'h33;
      cyc(3);
      covox = 1'b0;
      cyc(3);
      chk("b_race_upd", int'(ifb.sample_upd), 1);
      chk("b_race_sample", int'(ifb.sample), 8'h33);
      chk("b_race_idle", int'(ifb.idle), 0);
      cyc(14);
      chk("b_race_hold", int'(ifb.sample), 8'h33);
      cyc(1);
      chk("b_race_to", int'(ifb.idle), 1);

      // Reset mid-strobe, strobe continues after release
      covox = 1'b1;
      dbus  = 8'h55;
      cyc(2);
      #2 rst_n = 1'b0;
      cyc(2);
      chk("mid_rst_sample", int'(ifa.sample), 8'h80);
      #2 rst_n = 1'b1;
      cyc(3);
      covox = 1'b0;
      wait_upd("lat_55", 1'b0, 3);
      chk("sample_55_a", int'(ifa.sample), 8'h55);
      chk("sample_55_b", int'(ifb.sample), 8'h55);

      // Strobe that ends inside reset leaves nothing to commit
      covox = 1'b1;
      dbus  = 8'h66;
      cyc(2);
      #2 rst_n = 1'b0;
      cyc(1);
      covox = 1'b0;
      cyc(2);
      #2 rst_n = 1'b1;
      count_ones(8, ca, cb, nu);
      chk("stale_no_upd", nu, 0);
      chk("stale_sample", int'(ifa.sample), 8'h80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
